// File: rtl/qqspi_arbiter.sv
// Two-master round-robin arbiter and address decoder in front of the shared qqspi controller.
// Flash writes and unmapped addresses are answered locally with an error pulse, never reaching SPI.
module qqspi_arbiter #(
  parameter logic [31:0] FLASH_START     = 32'h2000_0000,
  parameter logic [31:0] FLASH_END       = 32'h2100_0000,
  parameter logic [31:0] PSRAM_START     = 32'h8000_0000,
  parameter logic [31:0] PSRAM_BANK_SIZE = 32'h0080_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        m1_err,
  output logic        mem_valid,
  output logic [22:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_psram,
  output logic [2:0]  mem_ce_ctrl,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [31:0] PSRAM_LO_END = PSRAM_START + PSRAM_BANK_SIZE;
  localparam logic [31:0] PSRAM_HI_END = PSRAM_LO_END + PSRAM_BANK_SIZE;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR, S_RECOVER} state_t;
  typedef enum logic [1:0] {D_ILLEGAL, D_FLASH, D_PSRAM_LO, D_PSRAM_HI} dec_t;

  function automatic dec_t f_decode(input logic [31:0] addr, input logic [3:0] wstrb);
    dec_t d;
    d = D_ILLEGAL;
    if (addr >= FLASH_START && addr < FLASH_END) begin
      if (wstrb == 4'd0) d = D_FLASH;
    end else if (addr >= PSRAM_START && addr < PSRAM_LO_END) begin
      d = D_PSRAM_LO;
    end else if (addr >= PSRAM_LO_END && addr < PSRAM_HI_END) begin
      d = D_PSRAM_HI;
    end
    return d;
  endfunction

  state_t      r_state;
  logic        r_last;
  logic        r_grant;
  logic [21:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  dec_t        r_dec;

  logic [1:0]  w_pend;
  logic        w_pick;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  dec_t        w_dec;
  logic        w_busy;
  logic        w_err;
  logic        w_xfer_done;
  logic        w_done;

  // On a tie the master that did not complete last wins; a lone requester always wins.
  assign w_pend  = {m1_valid, m0_valid};
  assign w_pick  = (w_pend == 2'b11) ? ~r_last : w_pend[1];
  assign w_addr  = w_pick ? m1_addr  : m0_addr;
  assign w_wdata = w_pick ? m1_wdata : m0_wdata;
  assign w_wstrb = w_pick ? m1_wstrb : m0_wstrb;
  assign w_dec   = f_decode(w_addr, w_wstrb);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_grant <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_dec   <= D_ILLEGAL;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_pend) begin
            r_grant <= w_pick;
            r_addr  <= w_addr[23:2];
            r_wdata <= w_wdata;
            r_wstrb <= w_wstrb;
            r_dec   <= w_dec;
            r_state <= (w_dec == D_ILLEGAL) ? S_ERR : S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            r_last  <= r_grant;
            r_state <= S_RECOVER;
          end
        end
        S_ERR: begin
          r_last  <= r_grant;
          r_state <= S_RECOVER;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Completion is combinational so the master sees ready in the same cycle as mem_ready.
  assign w_busy      = (r_state == S_BUSY);
  assign w_err       = (r_state == S_ERR);
  assign w_xfer_done = w_busy && mem_ready;
  assign w_done      = w_xfer_done || w_err;

  assign m0_ready = w_done && !r_grant;
  assign m1_ready = w_done &&  r_grant;
  assign m0_err   = w_err  && !r_grant;
  assign m1_err   = w_err  &&  r_grant;
  assign m0_rdata = (w_xfer_done && !r_grant) ? mem_rdata : 32'h0;
  assign m1_rdata = (w_xfer_done &&  r_grant) ? mem_rdata : 32'h0;

  assign mem_valid   = w_busy && !mem_ready;
  assign mem_addr    = {1'b0, r_addr};
  assign mem_wdata   = r_wdata;
  assign mem_wstrb   = r_wstrb;
  assign mem_psram   = w_busy && (r_dec == D_PSRAM_LO || r_dec == D_PSRAM_HI);
  assign mem_ce_ctrl = w_busy ? {r_dec == D_PSRAM_HI, r_dec == D_PSRAM_LO, r_dec == D_FLASH} : 3'b000;

endmodule
